// File: rtl/serial_audio_encoder_pkg.sv
// rtl/serial_audio_encoder_pkg.sv - shared constants and helpers for the serial audio encoder
//
// Contents:
//   SLOT_BITS, FRAME_CYCLES, CNT_W  slot width, clk128 cycles per frame, frame counter width
//   LEFT_LOAD, RIGHT_LOAD           frame counter values at which each channel's slot is loaded
//   fmt_t                           serial format encoding (FMT_LJ, FMT_I2S)
//   slot_is_left()                  lrclk channel of a slot for a given format
package serial_audio_encoder_pkg;

    localparam int SLOT_BITS    = 32;
    localparam int FRAME_CYCLES = 128;
    localparam int CNT_W        = $clog2(FRAME_CYCLES);

    localparam logic [CNT_W-1:0] LEFT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] RIGHT_LOAD = CNT_W'(FRAME_CYCLES / 2 - 1);

    typedef enum logic {
        FMT_LJ  = 1'b0,
        FMT_I2S = 1'b1
    } fmt_t;

    // I2S moves the word clock one slot ahead of the data; the 6-bit add
    // wraps slot 63 onto slot 0 so the next frame's left level appears early.
    function automatic logic slot_is_left(input fmt_t fmt, input logic [CNT_W-2:0] slot);
        logic [CNT_W-2:0] lead;
        lead = (fmt == FMT_I2S) ? slot + (CNT_W-1)'(1) : slot;
        return !lead[CNT_W-2];
    endfunction

endpackage

// File: rtl/serial_slot_shifter.sv
// rtl/serial_slot_shifter.sv - 32-bit load/shift register with a registered MSB output
//
// Ports:
//   clk128  master clock
//   reset   asynchronous active-high reset
//   load    load a new slot word (takes priority over shift)
//   shift   advance to the next bit
//   data    slot word, MSB transmitted first
//   q       current serial bit, driven from a flop
module serial_slot_shifter
    import serial_audio_encoder_pkg::*;
(
    input  logic                 clk128,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [SLOT_BITS-1:0] data,
    output logic                 q
);

    // sr holds the bits still to be sent after the one currently on q.
    logic [SLOT_BITS-1:0] sr;

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            sr <= '0;
            q  <= 1'b0;
        end else if (load) begin
            q  <= data[SLOT_BITS-1];
            sr <= {data[SLOT_BITS-2:0], 1'b0};
        end else if (shift) begin
            q  <= sr[SLOT_BITS-1];
            sr <= {sr[SLOT_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/serial_audio_encoder.sv
// rtl/serial_audio_encoder.sv - parallel L/R samples to LJ/I2S serial stream, bus master
//
// Optional feature macro: SERIAL_AUDIO_ENCODER_HOLD_EN (underrun repeats last sample
// delivered on that channel instead of sending silence).
//
// Ports:
//   clk128          master clock, 128fs
//   reset           asynchronous active-high reset
//   is_i2s          0 = left justified, 1 = I2S (sampled at frame end)
//   lrclk_polarity  0: lrclk low = left, 1: lrclk low = right (sampled at frame end)
//   i_valid         sample valid
//   i_ready         encoder can accept a sample on the expected channel
//   i_is_left       sample channel tag
//   i_audio         two's complement sample, AUDIO_WIDTH bits
//   sclk            bit clock, 64fs
//   lrclk           word clock, 1fs
//   sdout           serial data, MSB first, changes on sclk falling edge
//   is_error        one-cycle pulse: sample offered for the wrong channel
//   underrun        one-cycle pulse, aligned with the load cycle of an empty channel
module serial_audio_encoder
    import serial_audio_encoder_pkg::*;
#(
    parameter int AUDIO_WIDTH = 24
) (
    input  logic                   clk128,
    input  logic                   reset,
    input  logic                   is_i2s,
    input  logic                   lrclk_polarity,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_is_left,
    input  logic [AUDIO_WIDTH-1:0] i_audio,
    output logic                   sclk,
    output logic                   lrclk,
    output logic                   sdout,
    output logic                   is_error,
    output logic                   underrun
);

    logic [CNT_W-1:0]       cnt, cnt_n;
    fmt_t                   fmt, fmt_n;
    logic                   pol, pol_n;
    logic [AUDIO_WIDTH-1:0] l_hold, r_hold;
    logic [AUDIO_WIDTH-1:0] l_fill, r_fill;
    logic                   l_full, r_full, expect_left;
    logic                   l_full_n, r_full_n, expect_left_n;
    logic                   load_l, load_r, accept, take_l, take_r, bad_order;
    logic [SLOT_BITS-1:0]   load_word;

    function automatic logic [SLOT_BITS-1:0] to_slot(input logic [AUDIO_WIDTH-1:0] s);
        return SLOT_BITS'(s) << (SLOT_BITS - AUDIO_WIDTH);
    endfunction

`ifdef SERIAL_AUDIO_ENCODER_HOLD_EN
    logic [AUDIO_WIDTH-1:0] l_last, r_last;

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            l_last <= '0;
            r_last <= '0;
        end else begin
            if (load_l && l_full) l_last <= l_hold;
            if (load_r && r_full) r_last <= r_hold;
        end
    end

    assign l_fill = l_last;
    assign r_fill = r_last;
`else
    assign l_fill = '0;
    assign r_fill = '0;
`endif

    always_comb begin
        cnt_n     = cnt + CNT_W'(1);
        load_l    = (cnt == LEFT_LOAD);
        load_r    = (cnt == RIGHT_LOAD);
        accept    = i_valid && i_ready;
        take_l    = accept && i_is_left && expect_left;
        take_r    = accept && !i_is_left && !expect_left;
        bad_order = accept && (i_is_left != expect_left);
        // A load empties its register before a same-cycle accept refills it,
        // so that sample waits for the next frame.
        l_full_n      = take_l || (l_full && !load_l);
        r_full_n      = take_r || (r_full && !load_r);
        expect_left_n = expect_left ^ (take_l || take_r);
        fmt_n         = load_l ? fmt_t'(is_i2s) : fmt;
        pol_n         = load_l ? lrclk_polarity : pol;
        if (load_l) begin
            load_word = l_full ? to_slot(l_hold) : to_slot(l_fill);
        end else begin
            load_word = r_full ? to_slot(r_hold) : to_slot(r_fill);
        end
    end

    // Registered outputs are computed from next-state values so that each
    // one lines up with the cycle it describes.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            fmt         <= FMT_LJ;
            pol         <= 1'b0;
            l_hold      <= '0;
            r_hold      <= '0;
            l_full      <= 1'b0;
            r_full      <= 1'b0;
            expect_left <= 1'b1;
            i_ready     <= 1'b0;
            lrclk       <= 1'b0;
            is_error    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            fmt         <= fmt_n;
            pol         <= pol_n;
            if (take_l) l_hold <= i_audio;
            if (take_r) r_hold <= i_audio;
            l_full      <= l_full_n;
            r_full      <= r_full_n;
            expect_left <= expect_left_n;
            i_ready     <= expect_left_n ? !l_full_n : !r_full_n;
            lrclk       <= slot_is_left(fmt_n, cnt_n[CNT_W-1:1]) ? pol_n : !pol_n;
            is_error    <= bad_order;
            underrun    <= ((cnt_n == RIGHT_LOAD) && !r_full_n) ||
                           ((cnt_n == LEFT_LOAD) && !l_full_n);
        end
    end

    assign sclk = cnt[0];

    // One shifter serves both channels: left and right slots never overlap.
    serial_slot_shifter u_shifter (
        .clk128 (clk128),
        .reset  (reset),
        .load   (load_l || load_r),
        .shift  (cnt[0]),
        .data   (load_word),
        .q      (sdout)
    );

endmodule

// File: tb/tb_serial_audio_encoder.sv
// tb/tb_serial_audio_encoder.sv - self-checking bench for serial_audio_encoder
module tb_serial_audio_encoder;

    localparam int W         = 24;
    localparam int ST_IDLE   = 0;
    localparam int ST_STREAM = 1;
    localparam int ST_RANDOM = 2;

`ifdef SERIAL_AUDIO_ENCODER_HOLD_EN
    localparam logic [31:0] UR_RIGHT = 32'h7FFFFF00;
`else
    localparam logic [31:0] UR_RIGHT = 32'h00000000;
`endif

    logic         clk128 = 1'b0;
    logic         reset = 1'b1;
    logic         is_i2s = 1'b0;
    logic         lrclk_polarity = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_is_left = 1'b0;
    logic [W-1:0] i_audio = '0;
    logic         i_ready, sclk, lrclk, sdout, is_error, underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk128 = ~clk128;

    serial_audio_encoder #(.AUDIO_WIDTH(W)) dut (
        .clk128         (clk128),
        .reset          (reset),
        .is_i2s         (is_i2s),
        .lrclk_polarity (lrclk_polarity),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_is_left      (i_is_left),
        .i_audio        (i_audio),
        .sclk           (sclk),
        .lrclk          (lrclk),
        .sdout          (sdout),
        .is_error       (is_error),
        .underrun       (underrun)
    );

    // Reference model: one mailbox per channel (index 0 = left, 1 = right),
    // the word each channel is transmitting this frame, and the active mode.
    int           m_cnt;
    bit           m_full [2];
    logic [W-1:0] m_hold [2];
    logic [W-1:0] m_last [2];
    logic [31:0]  m_word [2];
    bit           m_expect_left, m_i2s, m_pol, m_err, m_ready_ok;

    // Stimulus and frame capture state
    int           stim = ST_IDLE;
    int           withhold = 0;
    logic [W-1:0] prod_l, prod_r;
    bit           cap_on = 0;
    int           cap_i, cap_under, cap_under_at, cap_err, hs_count, cap_notready;
    logic [31:0]  cap_word [2];
    logic         cap_lr [64];

    typedef struct {
        bit          i2s;
        bit          pol;
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic [3:0]  exp_lr;   // lrclk at slots {63, 32, 31, 0}
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_expect_left = 1;
        m_i2s = 0;
        m_pol = 0;
        m_err = 0;
        m_ready_ok = 0;
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 0;
            m_hold[c] = '0;
            m_last[c] = '0;
            m_word[c] = '0;
        end
    endtask

    function automatic bit exp_ready();
        return m_ready_ok && !m_full[m_expect_left ? 0 : 1];
    endfunction

    task automatic model_load(input int c);
        if (m_full[c]) begin
            m_word[c] = {m_hold[c], 8'h00};
            m_last[c] = m_hold[c];
        end else begin
`ifdef SERIAL_AUDIO_ENCODER_HOLD_EN
            m_word[c] = {m_last[c], 8'h00};
`else
            m_word[c] = '0;
`endif
        end
        m_full[c] = 0;
    endtask

    task automatic check_outputs();
        int  s;
        bit  left_slot;
        s = m_cnt / 2;
        left_slot = m_i2s ? (((s + 1) % 64) < 32) : (s < 32);
        chk("sclk", sclk, m_cnt % 2);
        chk("lrclk", lrclk, left_slot ? m_pol : !m_pol);
        chk("sdout", sdout, (s < 32) ? m_word[0][31 - s] : m_word[1][63 - s]);
        chk("i_ready", i_ready, exp_ready());
        chk("underrun", underrun, (m_cnt == 63 && !m_full[1]) || (m_cnt == 127 && !m_full[0]));
        chk("is_error", is_error, m_err);
        if (cap_on) begin
            if (cap_i % 2 == 1) begin
                s = cap_i / 2;
                if (s < 32) cap_word[0][31 - s] = sdout;
                else        cap_word[1][63 - s] = sdout;
                cap_lr[s] = lrclk;
            end
            if (underrun) begin
                cap_under++;
                cap_under_at = cap_i;
            end
            if (is_error) cap_err++;
            if (i_valid && i_ready) hs_count++;
            if (!i_ready) cap_notready++;
            cap_i++;
        end
    endtask

    task automatic model_update();
        bit acc;
        acc = i_valid && exp_ready();
        m_err = 0;
        if (m_cnt == 127) begin
            model_load(0);
            m_i2s = is_i2s;
            m_pol = lrclk_polarity;
        end
        if (m_cnt == 63) model_load(1);
        if (acc) begin
            if (i_is_left == m_expect_left) begin
                m_hold[i_is_left ? 0 : 1] = i_audio;
                m_full[i_is_left ? 0 : 1] = 1;
                m_expect_left = !m_expect_left;
            end else begin
                m_err = 1;
            end
        end
        m_ready_ok = 1;
        m_cnt = (m_cnt + 1) % 128;
    endtask

    task automatic step();
        @(negedge clk128);
        check_outputs();
        @(posedge clk128);
        model_update();
        #1;
    endtask

    task automatic drive();
        case (stim)
            ST_STREAM: begin
                i_valid   = !(withhold > 0 && !m_expect_left);
                i_is_left = m_expect_left;
                i_audio   = m_expect_left ? prod_l : prod_r;
            end
            ST_RANDOM: begin
                i_valid   = ($urandom_range(0, 3) != 0);
                i_is_left = ($urandom_range(0, 7) == 0) ? !m_expect_left : m_expect_left;
                i_audio   = W'($urandom);
                if ($urandom_range(0, 99) == 0) is_i2s = $urandom_range(0, 1);
                if ($urandom_range(0, 99) == 0) lrclk_polarity = $urandom_range(0, 1);
            end
            default: i_valid = 1'b0;
        endcase
        if (withhold > 0) withhold--;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            step();
        end
    endtask

    task automatic run_until(input int c);
        for (int k = 0; k < 128 && m_cnt != c; k++) begin
            drive();
            step();
        end
    endtask

    task automatic capture_frame();
        cap_on = 1;
        cap_i = 0;
        cap_under = 0;
        cap_under_at = -1;
        cap_err = 0;
        hs_count = 0;
        cap_notready = 0;
        cap_word[0] = '0;
        cap_word[1] = '0;
        run(128);
        cap_on = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_valid = 1'b0;
        #2;
        chk("rst_sclk", sclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdout", sdout, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_is_error", is_error, 0);
        chk("rst_ready", i_ready, 0);
        @(posedge clk128);
        #1;
        chk("rst_ready_held", i_ready, 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 24'h800001, 24'h7FFFFF, 32'h80000100, 32'h7FFFFF00, 4'b1100};
        vecs[1] = '{1'b1, 1'b1, 24'h800001, 24'h7FFFFF, 32'h80000100, 32'h7FFFFF00, 4'b1001};
        vecs[2] = '{1'b0, 1'b1, 24'h000001, 24'hFFFFFF, 32'h00000100, 32'hFFFFFF00, 4'b0011};
        vecs[3] = '{1'b1, 1'b0, 24'h123456, 24'hABCDEF, 32'h12345600, 32'hABCDEF00, 4'b0110};

        model_reset();
        repeat (3) @(posedge clk128);
        #1;
        do_reset();
        stim = ST_IDLE;
        run(1);
        chk("ready_after_release", i_ready, 1);
        chk("cnt_restart_sclk", sclk, 1);

        // Directed format/data vectors
        for (int v = 0; v < 4; v++) begin
            is_i2s = vecs[v].i2s;
            lrclk_polarity = vecs[v].pol;
            prod_l = vecs[v].l;
            prod_r = vecs[v].r;
            stim = ST_STREAM;
            run(3 * 128);
            run_until(0);
            capture_frame();
            chk("vec_left_word", cap_word[0], vecs[v].exp_l);
            chk("vec_right_word", cap_word[1], vecs[v].exp_r);
            chk("vec_lrclk", {cap_lr[63], cap_lr[32], cap_lr[31], cap_lr[0]}, vecs[v].exp_lr);
            chk("vec_no_underrun", cap_under, 0);
        end

        // Right channel starved for one frame
        is_i2s = 1'b0;
        lrclk_polarity = 1'b0;
        prod_l = 24'h800001;
        prod_r = 24'h7FFFFF;
        run(2 * 128);
        run_until(64);
        withhold = 128;
        run_until(0);
        capture_frame();
        chk("ur_left_word", cap_word[0], 32'h80000100);
        chk("ur_right_word", cap_word[1], UR_RIGHT);
        chk("ur_pulse_count", cap_under, 1);
        chk("ur_pulse_cnt", cap_under_at, 63);

        // Wrong channel first: dropped with an error pulse
        run(128);
        run_until(127);
        stim = ST_IDLE;
        run(1);
        i_valid = 1'b1;
        i_is_left = 1'b0;
        i_audio = 24'h55AA55;
        step();
        chk("order_err_pulse", is_error, 1);
        chk("order_ready_high", i_ready, 1);
        stim = ST_STREAM;
        run(1);
        chk("order_err_once", is_error, 0);
        run_until(0);
        capture_frame();
        chk("order_left_word", cap_word[0], 32'h80000100);
        chk("order_right_word", cap_word[1], 32'h7FFFFF00);
        chk("order_no_more_err", cap_err, 0);

        // Backpressure with i_valid held high
        capture_frame();
        chk("bp_handshakes", hs_count, 2);
        chk("bp_ready_low", cap_notready > 0, 1);

        // Randomized traffic and mode changes against the model
        stim = ST_RANDOM;
        run(2000);

        // Reset in mid-frame discards held samples
        run_until(41);
        do_reset();
        stim = ST_IDLE;
        capture_frame();
        chk("post_rst_left_word", cap_word[0], 0);
        chk("post_rst_right_word", cap_word[1], 0);
        chk("post_rst_underruns", cap_under, 2);
        chk("post_rst_last_ur", cap_under_at, 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_audio_encoder.md
Name: serial_audio_encoder

Overview:
- Inverse of serial_audio_decoder: accepts parallel 24-bit L/R samples on a valid/ready handshake and emits a serial audio stream as bus master (generates sclk, lrclk, sdout).
- Runs entirely on clk128. Produces a 64fs sclk with two 32-bit slots per frame.
- Feeds external DACs, and loops S/PDIF-path samples back to a serial bus in test setups.

Parameters:
- AUDIO_WIDTH, 24, sample width. Legal range 1..32. The sample is MSB-aligned in a 32-bit slot and the LSBs are zero-padded.

Ports:
- clk128  in  1  master clock, 128fs
- reset  in  1  asynchronous, active-high reset
- is_i2s  in  1  0 = Left Justified, 1 = I2S
- lrclk_polarity  in  1  0: lrclk Low = Left; 1: lrclk Low = Right
- i_valid  in  1  sample valid
- i_ready  out  1  encoder can accept a sample
- i_is_left  in  1  sample channel tag
- i_audio  in  AUDIO_WIDTH  sample, two's complement
- sclk  out  1  serial bit clock, 64fs
- lrclk  out  1  word clock, 1fs
- sdout  out  1  serial data, MSB first
- is_error  out  1  one-cycle pulse: channel-order violation
- underrun  out  1  one-cycle pulse: slot loaded with no sample available

Behaviour:
- Clock and reset: single clock, clk128. Reset is asynchronous and active-high.
- Frame counter:
  - cnt[6:0] is free-running 0..127 and wraps to 0. Reset value is 0.
  - slot = cnt[6:1], range 0..63.
  - Left data occupies slots 0..31; right data occupies slots 32..63.
- sclk: equals cnt[0]. It is low in the first clk128 cycle of each slot and high in the second.
- sdout: changes only when cnt[0]=0, i.e. on the sclk falling edge, so data is stable across the rising edge.
- Output drive: all outputs come directly from flops. No combinational glitches.
- lrclk timing:
  - LJ: left level when slot < 32.
  - I2S: left level when (slot+1) mod 64 < 32. lrclk therefore leads the data by one slot.
  - Left level = lrclk_polarity (0 means Low = Left).
- Mode sampling: is_i2s and lrclk_polarity are registered only at cnt==127. Changes take effect from the next frame.
- Holding registers: L_hold and R_hold, each with a full flag.
  - expect_left starts at 1.
  - i_ready = !full of the expected channel's register.
- Accept (i_valid && i_ready):
  - If i_is_left == expect_left: store the sample, set that register's full flag, toggle expect_left.
  - Otherwise: discard the sample, leave expect_left unchanged, pulse is_error.
- Load points:
  - At cnt==127 the left shift register loads from L_hold, and L full is cleared.
  - At cnt==63 the right shift register loads from R_hold, and R full is cleared.
  - Shift register contents = {sample, (32-AUDIO_WIDTH) zeros}. Shift one bit per slot.
- Underrun: a load from an empty register loads silence (0) and pulses underrun.
- Accept and load on the same cycle for the same register: the load sees the register empty (underrun, silence is output), and the accepted sample is stored for the next frame.
- Reset values:
  - cnt=0, sclk=0, sdout=0, lrclk=0.
  - is_error=0, underrun=0.
  - Holds empty, expect_left=1.
  - i_ready=0 while reset is asserted and 1 on the first cycle after release.
  - Mode registers = 0 (LJ, Low = Left) until the first cnt==127.
- Reset mid-frame: aborts immediately and discards held samples. The first frame after reset outputs silence and raises underrun at cnt==127 unless a sample has been accepted by then.

Optional Feature:
- Macro: SERIAL_AUDIO_ENCODER_HOLD_EN.
- Defined: on underrun the shift register reloads the last sample delivered on that channel (initially 0). The underrun pulse is still raised.
- Undefined: underrun loads 0.

Decomposition:
- Shared package holds:
  - the SLOT_BITS=32 and FRAME_CYCLES=128 constants;
  - the slot index boundaries (LEFT_LOAD=127, RIGHT_LOAD=63);
  - the format encoding (FMT_LJ=0, FMT_I2S=1).
- Sub-module serial_slot_shifter: a 32-bit load/shift register with a registered MSB output. It is instantiated once per channel, or once and time-shared.
- Counter, lrclk generation and the handshake stay in the top level.

Test Plan:
- Reset values: assert reset mid-frame -> all outputs 0 immediately; i_ready=1 one cycle after release; cnt restarts at 0.
- LJ data: LJ, polarity 0; feed L=0x800001, R=0x7FFFFF every frame.
  - sdout slots 0..31 = 0x80000100.
  - sdout slots 32..63 = 0x7FFFFF00.
  - lrclk Low in slots 0..31.
  - No underrun after the first frame.
- I2S framing: I2S, polarity 1 with the same data -> lrclk toggles at slot 63 and slot 31 (one slot before the MSB); data bits identical to the LJ case; the left level is High.
- Underrun: withhold R for one frame -> slots 32..63 are all zero and underrun pulses once at cnt==63. With SERIAL_AUDIO_ENCODER_HOLD_EN, the previous R=0x7FFFFF is repeated instead.
- Channel order: send R first -> is_error pulses once, the sample is dropped, i_ready stays high, and the following L then R are output correctly.
- Backpressure: hold i_valid high continuously -> exactly one L and one R are accepted per 128 cycles, and i_ready deasserts while the expected channel's register is full.
